// File: rtl/fluid_board_soc_dct_pkg.sv
// rtl/fluid_board_soc_dct_pkg.sv - shared widths and state type for the OCI trace-atom packer
package fluid_board_soc_dct_pkg;

  localparam int DCT_ATOM_W = 2;
  localparam int DCT_ATOMS  = 15;
  localparam int DCT_BUF_W  = DCT_ATOM_W * DCT_ATOMS;
  localparam int DCT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    CLOSE
  } dct_state_t;

endpackage

// File: rtl/fluid_board_soc_dct_out_reg.sv
// rtl/fluid_board_soc_dct_out_reg.sv - frame output register with valid/ready hold
// Loads a packed frame and holds it stable until the trace store takes it.
module fluid_board_soc_dct_out_reg
  import fluid_board_soc_dct_pkg::*;
#(
  parameter int BUF_W = DCT_BUF_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_i,
  input  logic [BUF_W-1:0]     data_i,
  input  logic [DCT_CNT_W-1:0] count_i,
  input  logic                 frm_ready_i,
  output logic                 frm_valid_o,
  output logic [BUF_W-1:0]     frm_data_o,
  output logic [DCT_CNT_W-1:0] frm_count_o,
  output logic                 out_free_o
);

  logic                 valid_q, valid_d;
  logic [BUF_W-1:0]     data_q, data_d;
  logic [DCT_CNT_W-1:0] count_q, count_d;

  assign out_free_o = !valid_q || frm_ready_i;

  // A load on the same edge as a take wins, so back-to-back frames never bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      count_d = count_i;
    end else if (frm_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign frm_valid_o = valid_q;
  assign frm_data_o  = data_q;
  assign frm_count_o = count_q;

endmodule

// File: rtl/fluid_board_soc_nios2_qsys_0_oci_dct_packer.sv
// rtl/fluid_board_soc_nios2_qsys_0_oci_dct_packer.sv - packs 2-bit trace atoms into 15-atom frames
// OCI_DCT_TIMEOUT_FLUSH_EN adds an idle counter that auto-flushes a stalled partial frame.
module fluid_board_soc_nios2_qsys_0_oci_dct_packer
  import fluid_board_soc_dct_pkg::*;
#(
  parameter int ATOM_W  = DCT_ATOM_W,
  parameter int ATOMS   = DCT_ATOMS,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      atom_valid,
  input  logic [ATOM_W-1:0]         atom_data,
  output logic                      atom_ready,
  input  logic                      flush,
  output logic                      frm_valid,
  input  logic                      frm_ready,
  output logic [ATOM_W*ATOMS-1:0]   frm_data,
  output logic [DCT_CNT_W-1:0]      frm_count,
  output logic [ATOM_W*ATOMS-1:0]   dct_buffer,
  output logic [DCT_CNT_W-1:0]      dct_count
);

  localparam int                   BUF_W = ATOM_W * ATOMS;
  localparam logic [DCT_CNT_W-1:0] FULL  = DCT_CNT_W'(ATOMS);

  logic [BUF_W-1:0]     stage_q, stage_d;
  logic [DCT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 flush_pend_q, flush_pend_d;
  dct_state_t           state_q, state_d;
  logic                 out_free, accept, transfer, flush_req;

  assign atom_ready = (cnt_q != FULL) || out_free;
  assign accept     = atom_valid && atom_ready;
  assign transfer   = (state_q == CLOSE) && out_free;

`ifdef OCI_DCT_TIMEOUT_FLUSH_EN
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMR_W-1:0] idle_q, idle_d;
  logic             timeout_hit;

  assign timeout_hit = (idle_q == TMR_W'(TIMEOUT - 1));
  assign flush_req   = flush || timeout_hit;

  // Restarting after a hit makes the timeout a single-cycle pseudo-flush.
  always_comb begin
    idle_d = idle_q + TMR_W'(1);
    if (accept || transfer || (cnt_q == '0) || timeout_hit) idle_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idle_q <= '0;
    else          idle_q <= idle_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign flush_req      = flush;
`endif

  // Transfer empties staging first, so an atom taken on that edge starts the next frame.
  always_comb begin
    stage_d      = stage_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    if (transfer) begin
      stage_d      = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end
    if (accept && (cnt_d != FULL)) begin
      stage_d = {stage_d[BUF_W-ATOM_W-1:0], atom_data};
      cnt_d   = cnt_d + DCT_CNT_W'(1);
    end
    if (flush_req && (cnt_d != '0)) flush_pend_d = 1'b1;

    if (cnt_d == '0)                       state_d = IDLE;
    else if ((cnt_d == FULL) || flush_pend_d) state_d = CLOSE;
    else                                   state_d = FILL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q      <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      state_q      <= IDLE;
    end else begin
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      state_q      <= state_d;
    end
  end

  fluid_board_soc_dct_out_reg #(
    .BUF_W(BUF_W)
  ) u_out_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (transfer),
    .data_i     (stage_q),
    .count_i    (cnt_q),
    .frm_ready_i(frm_ready),
    .frm_valid_o(frm_valid),
    .frm_data_o (frm_data),
    .frm_count_o(frm_count),
    .out_free_o (out_free)
  );

  assign dct_buffer = stage_q;
  assign dct_count  = cnt_q;

endmodule

// File: tb/tb_fluid_board_soc_nios2_qsys_0_oci_dct_packer.sv
// tb/tb_fluid_board_soc_nios2_qsys_0_oci_dct_packer.sv - self-checking bench for the trace-atom packer
module tb_fluid_board_soc_nios2_qsys_0_oci_dct_packer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'd0;
  logic        flush = 1'b0;
  logic        frm_ready = 1'b0;
  logic        atom_ready;
  logic        frm_valid;
  logic [29:0] frm_data;
  logic [3:0]  frm_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  always #5 clk = ~clk;

  fluid_board_soc_nios2_qsys_0_oci_dct_packer #(
    .ATOM_W(2), .ATOMS(15), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .atom_valid(atom_valid), .atom_data(atom_data), .atom_ready(atom_ready),
    .flush(flush),
    .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_data(frm_data), .frm_count(frm_count),
    .dct_buffer(dct_buffer), .dct_count(dct_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: staging as a queue of atoms, output frame as plain values.
  int     q[$];
  int     sb[$];
  bit     m_pend, m_fv;
  longint m_fd;
  int     m_fc;
  int     m_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint pack_q();
    longint r = 0;
    foreach (q[i]) r = r * 4 + q[i];
    return r;
  endfunction

  task automatic m_reset();
    q.delete(); sb.delete();
    m_pend = 0; m_fv = 0; m_fd = 0; m_fc = 0; m_idle = 0;
  endtask

  always @(negedge reset_n) m_reset();

  always @(posedge clk) begin
    if (!reset_n) m_reset();
    else begin : upd
      bit ofree, xfer, acc, freq;
      ofree = !m_fv || frm_ready;
      xfer  = ((q.size() == 15) || (m_pend && q.size() != 0)) && ofree;
      acc   = atom_valid && ((q.size() != 15) || ofree);
      freq  = flush;
`ifdef OCI_DCT_TIMEOUT_FLUSH_EN
      begin : tmo
        bit hit;
        hit    = (m_idle == TO - 1);
        freq   = freq || hit;
        m_idle = (acc || xfer || q.size() == 0 || hit) ? 0 : m_idle + 1;
      end
`endif
      if (xfer) begin
        m_fv = 1; m_fd = pack_q(); m_fc = q.size(); q.delete(); m_pend = 0;
      end else if (frm_ready) m_fv = 0;
      if (acc) begin
        q.push_back(int'(atom_data));
        sb.push_back(int'(atom_data));
      end
      if (freq && q.size() != 0) m_pend = 1;
    end
  end

  always @(negedge clk) begin
    chk("atom_ready", {31'd0, atom_ready}, {31'd0, (q.size() != 15) || !m_fv || frm_ready});
    chk("frm_valid",  {31'd0, frm_valid},  {31'd0, m_fv});
    chk("frm_data",   {2'd0, frm_data},    m_fd[31:0]);
    chk("frm_count",  {28'd0, frm_count},  32'(m_fc));
    chk("dct_buffer", {2'd0, dct_buffer},  32'(pack_q()));
    chk("dct_count",  {28'd0, dct_count},  32'(q.size()));
    if (reset_n && frm_valid && frm_ready) begin : take
      int n;
      longint e;
      n = int'(frm_count);
      e = 0;
      chk("order_avail", {31'd0, (n > 0) && (sb.size() >= n)}, 32'd1);
      if (n > 0 && sb.size() >= n) begin
        for (int i = 0; i < n; i++) e = e * 4 + sb.pop_front();
        chk("order_data", {2'd0, frm_data}, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [29:0] exp_full;

  initial begin
    exp_full = 30'(32'h39393939);
    step(); step();
    chk("rst_atom_ready", {31'd0, atom_ready}, 32'd1);
    chk("rst_frm_valid",  {31'd0, frm_valid}, 32'd0);
    chk("rst_dct_count",  {28'd0, dct_count}, 32'd0);
    reset_n = 1'b1;
    step();

    // 15 atoms 3,2,1,0,... with the store always ready
    frm_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      atom_valid = 1'b1; atom_data = 2'(3 - (i % 4)); step();
    end
    atom_valid = 1'b0;
    chk("full_not_yet", {31'd0, frm_valid}, 32'd0);
    chk("full_cnt15",   {28'd0, dct_count}, 32'd15);
    step();
    chk("full_valid", {31'd0, frm_valid}, 32'd1);
    chk("full_data",  {2'd0, frm_data},   {2'd0, exp_full});
    chk("full_count", {28'd0, frm_count}, 32'd15);
    chk("full_drain", {28'd0, dct_count}, 32'd0);

    // 5 atoms of 1 then flush
    for (int i = 0; i < 5; i++) begin
      atom_valid = 1'b1; atom_data = 2'd1; step();
    end
    atom_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0; step();
    chk("fl_valid", {31'd0, frm_valid}, 32'd1);
    chk("fl_count", {28'd0, frm_count}, 32'd5);
    chk("fl_data",  {2'd0, frm_data},   32'h155);
    chk("fl_dct",   {28'd0, dct_count}, 32'd0);
    step();

    // backpressure: 30 atoms against a stalled store
    frm_ready = 1'b0; atom_valid = 1'b1;
    for (int i = 0; i < 31; i++) begin
      atom_data = 2'($urandom_range(0, 3)); step();
    end
    chk("bp_ready0", {31'd0, atom_ready}, 32'd0);
    chk("bp_cnt15",  {28'd0, dct_count}, 32'd15);
    chk("bp_fcnt",   {28'd0, frm_count}, 32'd15);
    frm_ready = 1'b1; atom_valid = 1'b0;
    step(); step(); step();

    // flush with nothing staged is dropped; flush with the first atom closes a 1-atom frame
    flush = 1'b1; step(); flush = 1'b0; step();
    chk("fl0_none", {31'd0, frm_valid}, 32'd0);
    frm_ready = 1'b0;
    atom_valid = 1'b1; atom_data = 2'd2; flush = 1'b1; step();
    atom_valid = 1'b0; flush = 1'b0; step();
    chk("fl1_valid", {31'd0, frm_valid}, 32'd1);
    chk("fl1_count", {28'd0, frm_count}, 32'd1);
    chk("fl1_data",  {2'd0, frm_data},   32'd2);

    // atoms taken while a flush waits on a stalled store join the closing frame
    atom_valid = 1'b1; atom_data = 2'd1; flush = 1'b1; step();
    flush = 1'b0; atom_data = 2'd3; step();
    atom_data = 2'd0; step();
    atom_valid = 1'b0;
    chk("pend_dct",  {28'd0, dct_count}, 32'd3);
    chk("pend_hold", {28'd0, frm_count}, 32'd1);
    frm_ready = 1'b1; step();
    chk("pend_count", {28'd0, frm_count}, 32'd3);
    chk("pend_data",  {2'd0, frm_data},   32'h1c);

    // reset mid-frame with a held output frame
    frm_ready = 1'b0; atom_valid = 1'b1; step(); step(); atom_valid = 1'b0;
    reset_n = 1'b0; #1;
    chk("mrst_valid", {31'd0, frm_valid}, 32'd0);
    chk("mrst_data",  {2'd0, frm_data},   32'd0);
    chk("mrst_count", {28'd0, frm_count}, 32'd0);
    chk("mrst_buf",   {2'd0, dct_buffer}, 32'd0);
    chk("mrst_dct",   {28'd0, dct_count}, 32'd0);
    step(); step(); reset_n = 1'b1; step();

    // idle partial frame: auto-flush only when the timeout feature is built
    for (int i = 1; i <= 3; i++) begin
      atom_valid = 1'b1; atom_data = 2'(i); step();
    end
    atom_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
`ifdef OCI_DCT_TIMEOUT_FLUSH_EN
    chk("tmo_valid", {31'd0, frm_valid}, 32'd1);
    chk("tmo_count", {28'd0, frm_count}, 32'd3);
    chk("tmo_data",  {2'd0, frm_data},   32'h1b);
`else
    chk("tmo_none",  {31'd0, frm_valid}, 32'd0);
    chk("tmo_dct",   {28'd0, dct_count}, 32'd3);
`endif

    // randomized traffic with varying store pressure
    for (int c = 0; c < 4000; c++) begin
      int rdy_pct;
      rdy_pct = ((c / 200) % 3 == 0) ? 20 : (((c / 200) % 3 == 1) ? 70 : 100);
      atom_valid = ($urandom_range(0, 3) != 0);
      atom_data  = 2'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 15) == 0);
      frm_ready  = ($urandom_range(1, 100) <= rdy_pct);
      step();
    end

    atom_valid = 1'b0; frm_ready = 1'b1; flush = 1'b1; step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("end_lost",  32'(sb.size()), 32'd0);
    chk("end_dct",   {28'd0, dct_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fluid_board_soc_nios2_qsys_0_oci_dct_packer.md
# fluid_board_soc_nios2_qsys_0_oci_dct_packer

Producer side of the Nios II OCI compressed-trace path: it packs 2-bit trace atoms from the debug core into 30-bit frames (15 atoms) with a 4-bit atom count. It hands each frame to the trace store over a valid/ready handshake. The live `dct_buffer` and `dct_count` outputs feed the OCI test-bench monitor.

## Interface
Parameters:
- `ATOM_W`, 2: bits per trace atom.
- `ATOMS`, 15: atoms per frame; frame width is `ATOM_W*ATOMS` = 30.
- `TIMEOUT`, 64: idle cycles before an auto-flush (used only with the macro).

Ports:
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `atom_valid` in 1: an atom is offered.
- `atom_data` in 2: atom value.
- `atom_ready` out 1: the atom is accepted when both `atom_valid` and `atom_ready` are high.
- `flush` in 1: pulse that closes the current partial frame.
- `frm_valid` out 1: a frame is held on the frame outputs.
- `frm_ready` in 1: the downstream takes the frame.
- `frm_data` out 30: packed atoms; the oldest atom is in the MSBs, the newest in `[1:0]`.
- `frm_count` out 4: number of valid atoms in the frame, 1..15, right-aligned.
- `dct_buffer` out 30: live staging buffer.
- `dct_count` out 4: live staging count, 0..15.

## Operation
Staging buffer:
- On accept: `dct_buffer <= {dct_buffer[27:0], atom_data}` and `dct_count <= dct_count+1`.
- The count saturates at 15 and never wraps.
- `atom_ready = (dct_count != 15) || out_free`, where `out_free = !frm_valid || frm_ready`.

Transfer: the staging buffer is copied to the output register on the edge ending any cycle in which both of these hold:
- Close condition: `dct_count == 15`, or (`flush_pend` and `dct_count != 0`).
- `out_free` is high.

Effects of a transfer edge:
- `frm_data` and `frm_count` load; `frm_valid` is set.
- The staging buffer clears, `dct_count` goes to 0 and `flush_pend` clears.
- An atom accepted in the same cycle becomes atom 1 of the new frame: `dct_buffer = {28'b0, atom_data}`, `dct_count = 1`.

Flush rules:
- `flush` sets `flush_pend`.
- An atom accepted in the same cycle as `flush`, or while `flush_pend` is set, belongs to the closing frame.
- A flush with `dct_count == 0` and no atom accepted in that cycle is dropped; `flush_pend` stays 0.

Output handshake:
- `frm_valid` clears on `frm_ready` unless a new transfer happens on the same edge.
- The frame outputs are stable while `frm_valid && !frm_ready`.

State machine (`dct_state_t`):
- `IDLE`: count = 0. Goes to `FILL` on accept.
- `FILL`: 0 < count < 15, no flush pending. Goes to `CLOSE` when count reaches 15 or a flush arrives.
- `CLOSE`: close condition true, waiting for `out_free`. Leaves on the transfer edge: to `FILL` if an atom was taken in that cycle, else to `IDLE`.

## Timing
- All registers reset asynchronously.
- Reset values: `dct_buffer`=0, `dct_count`=0, `frm_data`=0, `frm_count`=0, `frm_valid`=0, state `IDLE`, `flush_pend`=0.
- `atom_ready` is combinational and reads 1 after reset.
- Latency:
  - 15th atom accepted at edge N: `frm_valid` is 1 after edge N+1 if `out_free` holds.
  - Flush sampled at edge N: the frame is valid after edge N+1.
- Backpressure: with the staging buffer full and the output register held, `atom_ready` is 0. No atom is ever dropped.
- Throughput: one atom per cycle is sustained when `frm_ready` is held at 1.
- Reset asserted mid-frame discards both the staging buffer and the output frame.

## Configuration
- Macro: `OCI_DCT_TIMEOUT_FLUSH_EN`.
- Defined:
  - An idle counter counts cycles with `dct_count != 0` and no accept.
  - Any accept, or a transfer, resets the counter to 0.
  - When the counter reaches `TIMEOUT-1`, it sets `flush_pend` exactly as a `flush` pulse would.
- Undefined: no counter is built, and frames close only on full or on `flush`.

## Structure
- Package `fluid_board_soc_dct_pkg`:
  - Constants `DCT_ATOM_W`, `DCT_ATOMS`, `DCT_BUF_W` (30) and `DCT_CNT_W` (4).
  - Enum `dct_state_t` with states `IDLE`, `FILL`, `CLOSE`.
- One sub-module: `fluid_board_soc_dct_out_reg`, the frame output register that owns the `frm_valid`/`frm_ready` hold logic and exports `out_free`.

## Test plan
- Feed 15 atoms, values 3,2,1,0,… repeating, with `frm_ready`=1 → one frame with `frm_count`=15 and `frm_data`=30'h39393939 (MSB-first 3,2,1,0 pattern). `frm_valid` rises one edge after the 15th accept.
- Feed 5 atoms of value 1, then `flush` → `frm_count`=5, `frm_data`=30'h155. `dct_count` returns to 0.
- Hold `frm_ready`=0, then feed 30 atoms → the first frame is held stable; the second frame fills to 15; `atom_ready`=0 until `frm_ready` is raised. Both frames arrive in order and no atom is lost.
- Assert `flush` with `dct_count`=0 → no frame. Assert `flush` together with the first atom (value 2) → frame with count 1 and data 2.
- With `frm_ready` low and a flush pending, feed 2 more atoms → all of them are in the flushed frame. Assert `reset_n` mid-frame → all outputs 0 on the same cycle.
- With `OCI_DCT_TIMEOUT_FLUSH_EN` and `TIMEOUT`=8: send 3 atoms, then idle → frame with count 3 issued after the 8th idle cycle. Without the macro, no frame is issued.
